// File: rtl/deco_instructions_pkg.sv
// Shared definitions for the instruction decoder.
// Holds the instruction-class codes, field widths and bit positions, and the
// packed struct that carries one set of decoded fields.
package deco_instructions_pkg;

  localparam int unsigned INSTRUCTION_SIZE = 16;
  localparam int unsigned TYPES            = 2;
  localparam int unsigned REG_ADDR         = 3;
  localparam int unsigned ADDR_W           = 13;
  localparam int unsigned IMM_W            = 10;

  // Instruction class codes, taken from instruction[15:14].
  localparam logic [TYPES-1:0] TYPE_M = 2'b00;
  localparam logic [TYPES-1:0] TYPE_R = 2'b01;
  localparam logic [TYPES-1:0] TYPE_I = 2'b10;
  localparam logic [TYPES-1:0] TYPE_J = 2'b11;

  // Field bit positions (MSB/LSB) within the 16-bit instruction word.
  localparam int unsigned TYPE_MSB    = 15;
  localparam int unsigned TYPE_LSB    = 14;
  localparam int unsigned DEST_MSB    = 13;  // R and M types
  localparam int unsigned DEST_LSB    = 11;
  localparam int unsigned SRC1_MSB    = 10;
  localparam int unsigned SRC1_LSB    = 8;
  localparam int unsigned SRC2_MSB    = 7;
  localparam int unsigned SRC2_LSB    = 5;
  localparam int unsigned MADDR_MSB   = 10;  // M-type address, zero-extended
  localparam int unsigned JADDR_MSB   = 12;  // J-type address
  localparam int unsigned IDEST_MSB   = 12;  // I-type destination
  localparam int unsigned IDEST_LSB   = 10;
  localparam int unsigned IMM_MSB     = 9;

  typedef struct packed {
    logic [TYPES-1:0]    itype;
    logic [REG_ADDR-1:0] src1;
    logic [REG_ADDR-1:0] src2;
    logic [REG_ADDR-1:0] dest;
    logic [ADDR_W-1:0]   addr;
    logic [IMM_W-1:0]    imm;
  } deco_fields_t;

endpackage

// File: rtl/deco_fields_comb.sv
// Purely combinational field extractor for one instruction word.
// Ports:
//   instruction  in   16-bit instruction word
//   fields       out  decoded fields; fields unused by the class are zero
module deco_fields_comb
  import deco_instructions_pkg::*;
(
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  output deco_fields_t                fields
);

  logic [TYPES-1:0] itype;
  assign itype = instruction[TYPE_MSB:TYPE_LSB];

  always_comb begin
    fields       = '0;
    fields.itype = itype;
    unique case (itype)
      TYPE_R: begin
        fields.dest = instruction[DEST_MSB:DEST_LSB];
        fields.src1 = instruction[SRC1_MSB:SRC1_LSB];
        fields.src2 = instruction[SRC2_MSB:SRC2_LSB];
      end
      TYPE_M: begin
        fields.dest = instruction[DEST_MSB:DEST_LSB];
        fields.addr = {2'b00, instruction[MADDR_MSB:0]};
      end
      TYPE_J: begin
        // Bit 13 is not part of the jump target.
        fields.addr = instruction[JADDR_MSB:0];
      end
      TYPE_I: begin
        // Bit 13 is reserved; the immediate is passed raw.
        fields.dest = instruction[IDEST_MSB:IDEST_LSB];
        fields.imm  = instruction[IMM_MSB:0];
      end
      default: fields = '0;
    endcase
  end

endmodule

// File: rtl/deco_instructions.sv
// Instruction decoder between fetch and register file / execute.
// Decodes the instruction combinationally and registers the fields on a
// valid instruction; out_valid follows in_valid with one cycle of latency.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_valid     in   instruction present this cycle
//   instruction  in   instruction word
//   out_valid    out  decoded fields valid
//   instr_type   out  instruction class, instruction[15:14]
//   src1, src2   out  source register addresses
//   dest         out  destination register address
//   addr         out  memory / jump address
//   imm          out  immediate
module deco_instructions
  import deco_instructions_pkg::*;
#(
  parameter int unsigned INSTRUCTION_SIZE = deco_instructions_pkg::INSTRUCTION_SIZE,
  parameter int unsigned TYPES            = deco_instructions_pkg::TYPES,
  parameter int unsigned REG_ADDR         = deco_instructions_pkg::REG_ADDR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [INSTRUCTION_SIZE-1:0]   instruction,
  output logic                          out_valid,
  output logic [TYPES-1:0]              instr_type,
  output logic [REG_ADDR-1:0]           src1,
  output logic [REG_ADDR-1:0]           src2,
  output logic [REG_ADDR-1:0]           dest,
  output logic [INSTRUCTION_SIZE-4:0]   addr,
  output logic [INSTRUCTION_SIZE-7:0]   imm
);

  deco_fields_t fields_d;
  deco_fields_t fields_q;
  logic         valid_q;

  deco_fields_comb u_fields (
    .instruction (instruction),
    .fields      (fields_d)
  );

  // Fields load only on a valid instruction and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fields_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        fields_q <= fields_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign instr_type = fields_q.itype;
  assign src1       = fields_q.src1;
  assign src2       = fields_q.src2;
  assign dest       = fields_q.dest;
  assign addr       = fields_q.addr;
  assign imm        = fields_q.imm;

endmodule

// File: tb/tb_deco_instructions.sv
// Directed self-checking bench for deco_instructions.
module tb_deco_instructions;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] instruction;
  logic        out_valid;
  logic [1:0]  instr_type;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [2:0]  dest;
  logic [12:0] addr;
  logic [9:0]  imm;

  int unsigned n_checks;
  int unsigned n_pass;

  deco_instructions dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .out_valid   (out_valid),
    .instr_type  (instr_type),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .addr        (addr),
    .imm         (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [15:0] VecR = 16'b0100111011101110;
  localparam logic [15:0] VecM = 16'b0010111011101110;
  localparam logic [15:0] VecJ = 16'b1100111011101110;
  localparam logic [15:0] VecI = 16'b1010110000000101;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [1:0] et,
                           input logic [2:0] ed, input logic [2:0] es1,
                           input logic [2:0] es2, input logic [12:0] ea,
                           input logic [9:0] ei);
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".type"},  32'(instr_type), 32'(et));
    check({tag, ".dest"},  32'(dest), 32'(ed));
    check({tag, ".src1"},  32'(src1), 32'(es1));
    check({tag, ".src2"},  32'(src2), 32'(es2));
    check({tag, ".addr"},  32'(addr), 32'(ea));
    check({tag, ".imm"},   32'(imm), 32'(ei));
  endtask

  // Hand-decoded expectations for each vector.
  task automatic exp_r(input string tag, input logic v);
    check_out(tag, v, 2'b01, 3'b001, 3'b110, 3'b111, 13'd0, 10'd0);
  endtask
  task automatic exp_m(input string tag, input logic v);
    check_out(tag, v, 2'b00, 3'b101, 3'b000, 3'b000, 13'b0011011101110, 10'd0);
  endtask
  task automatic exp_j(input string tag, input logic v);
    check_out(tag, v, 2'b11, 3'b000, 3'b000, 3'b000, 13'b0111011101110, 10'd0);
  endtask
  task automatic exp_i(input string tag, input logic v);
    check_out(tag, v, 2'b10, 3'b011, 3'b000, 3'b000, 13'd0, 10'b0000000101);
  endtask
  task automatic exp_zero(input string tag);
    check_out(tag, 1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 13'd0, 10'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    instruction = '0;
    #3;
    exp_zero("reset");

    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_zero("idle_after_reset");

    // Single instructions, each checked one cycle later.
    in_valid = 1'b1; instruction = VecR;
    @(negedge clk); in_valid = 1'b0;
    exp_r("r_single", 1'b1);
    in_valid = 1'b1; instruction = VecM;
    @(negedge clk); in_valid = 1'b0;
    exp_m("m_single", 1'b1);
    in_valid = 1'b1; instruction = VecJ;
    @(negedge clk); in_valid = 1'b0;
    exp_j("j_single", 1'b1);
    in_valid = 1'b1; instruction = VecI;
    @(negedge clk); in_valid = 1'b0;
    exp_i("i_single", 1'b1);

    // Back-to-back stream, then hold.
    @(negedge clk);
    in_valid = 1'b1; instruction = VecR;
    @(negedge clk); exp_r("r_stream", 1'b1); instruction = VecM;
    @(negedge clk); exp_m("m_stream", 1'b1); instruction = VecJ;
    @(negedge clk); exp_j("j_stream", 1'b1); instruction = VecI;
    @(negedge clk); exp_i("i_stream", 1'b1); in_valid = 1'b0; instruction = VecR;
    @(negedge clk); exp_i("hold", 1'b0);
    @(negedge clk); exp_i("hold2", 1'b0);

    // Asynchronous reset mid-stream clears outputs before the next edge.
    in_valid = 1'b1; instruction = VecM;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 exp_zero("async_reset");
    in_valid = 1'b1; instruction = VecJ;
    @(negedge clk);
    exp_zero("reset_held_with_valid");
    rst = 1'b0;
    @(negedge clk);
    exp_j("first_after_reset", 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    exp_j("hold_after_reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
